// File: rtl/shift_out_driver.sv
// ----------------------------------------------------------------------------
// shift_out_driver
//
// Serialises a parallel word onto a 74HC595-style shift-register chain
// (LED bank / 7-segment digits) as sclk / sdat / slatch. It sits between the
// core logic and the board pins, the output-side twin of the debounced input
// path. Core logic raises start for a frame, watches busy, and gets a single
// done pulse when the storage registers have been latched.
//
// Parameters
//   DATA_W    bits per frame (>= 1)
//   CLK_DIV   clk_100mhz cycles per sclk half-period (>= 1)
//   MSB_FIRST 1: data_in[DATA_W-1] leaves first, 0: data_in[0] leaves first
//
// Ports
//   clk_100mhz  in   1       system clock, rising edge
//   rst_n       in   1       synchronous reset, active-low
//   data_in     in   DATA_W  frame payload, sampled only when start is accepted
//   start       in   1       frame request, level-sampled while idle
//   busy        out  1       frame in progress
//   done        out  1       one-cycle pulse when the frame has been latched
//   sclk        out  1       shift clock to the chain, data valid on its rise
//   sdat        out  1       serial data to the chain
//   slatch      out  1       storage-register latch, active-high
//
// Every output comes straight from a flop, so nothing from the inputs reaches
// the pins combinationally.
// ----------------------------------------------------------------------------
module shift_out_driver #(
    parameter int DATA_W    = 16,
    parameter int CLK_DIV   = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              clk_100mhz,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] data_in,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              sclk,
    output logic              sdat,
    output logic              slatch
);

    // Counter widths: the divider counts phase cycles 0..CLK_DIV-1, the bit
    // counter indexes bits 0..DATA_W-1. Both return to zero at the end of
    // their phase/frame, so they never need to hold their terminal+1 value.
    localparam int DIV_W = $clog2(CLK_DIV + 1);
    localparam int BIT_W = $clog2(DATA_W + 1);

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_W - 1);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        SHIFT_LO = 2'd1,
        SHIFT_HI = 2'd2,
        LATCH    = 2'd3
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [DIV_W-1:0]  div_q;
    logic [DIV_W-1:0]  div_d;
    logic [BIT_W-1:0]  bit_q;
    logic [BIT_W-1:0]  bit_d;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;

    logic              busy_d;
    logic              done_d;
    logic              sclk_d;
    logic              sdat_d;
    logic              slatch_d;

    logic              phase_end;
    logic              last_bit;
    logic [DATA_W-1:0] shift_adv;
    logic              adv_bit;
    logic              load_bit;

    // Helper terms shared by the next-state and output logic.
    // The outgoing bit always lives at one fixed end of shift_q; advancing
    // shifts the word towards that end so the next bit takes its place.
    // Doing the shift first and then picking the end bit keeps DATA_W=1 legal.
    always_comb begin
        phase_end = (div_q == DIV_LAST);
        last_bit  = (bit_q == BIT_LAST);
        if (MSB_FIRST) begin
            shift_adv = shift_q << 1;
            adv_bit   = shift_adv[DATA_W-1];
            load_bit  = data_in[DATA_W-1];
        end else begin
            shift_adv = shift_q >> 1;
            adv_bit   = shift_adv[0];
            load_bit  = data_in[0];
        end
    end

    // State and datapath registers, including every output pin. Reset is
    // synchronous; asserting it mid-frame simply drops the frame, and since
    // slatch is cleared with everything else the chain never latches a
    // partially shifted word.
    always_ff @(posedge clk_100mhz) begin
        if (!rst_n) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sclk    <= 1'b0;
            sdat    <= 1'b0;
            slatch  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            busy    <= busy_d;
            done    <= done_d;
            sclk    <= sclk_d;
            sdat    <= sdat_d;
            slatch  <= slatch_d;
        end
    end

    // Next-state logic. Each non-idle state lasts exactly CLK_DIV cycles
    // (one sclk half-period); SHIFT_HI decides between another bit and the
    // latch phase. start is only looked at in IDLE, so requests made while a
    // frame is running are dropped rather than queued.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT_LO;
                end
            end
            SHIFT_LO: begin
                if (phase_end) begin
                    state_d = SHIFT_HI;
                end
            end
            SHIFT_HI: begin
                if (phase_end) begin
                    state_d = last_bit ? LATCH : SHIFT_LO;
                end
            end
            LATCH: begin
                if (phase_end) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Datapath and output values for the next cycle.
    // Outputs are computed one cycle ahead and registered, so each pin
    // reflects the phase the FSM is in. sdat only ever moves on the edge
    // where sclk drops (or at frame load while sclk is already low), giving
    // the chain a full half-period of setup and hold around each sclk rise.
    // The done cycle is the first IDLE cycle; start seen there launches the
    // next frame immediately.
    always_comb begin
        div_d    = div_q;
        bit_d    = bit_q;
        shift_d  = shift_q;
        busy_d   = busy;
        done_d   = 1'b0;
        sclk_d   = sclk;
        sdat_d   = sdat;
        slatch_d = slatch;

        case (state_q)
            IDLE: begin
                div_d    = '0;
                bit_d    = '0;
                busy_d   = 1'b0;
                sclk_d   = 1'b0;
                sdat_d   = 1'b0;
                slatch_d = 1'b0;
                if (start) begin
                    shift_d = data_in;
                    sdat_d  = load_bit;
                    busy_d  = 1'b1;
                end
            end

            SHIFT_LO: begin
                sclk_d = 1'b0;
                if (phase_end) begin
                    div_d  = '0;
                    sclk_d = 1'b1;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end

            SHIFT_HI: begin
                sclk_d = 1'b1;
                if (phase_end) begin
                    div_d  = '0;
                    sclk_d = 1'b0;
                    if (last_bit) begin
                        bit_d    = '0;
                        sdat_d   = 1'b0;
                        slatch_d = 1'b1;
                    end else begin
                        bit_d   = bit_q + BIT_ONE;
                        shift_d = shift_adv;
                        sdat_d  = adv_bit;
                    end
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end

            LATCH: begin
                sclk_d   = 1'b0;
                sdat_d   = 1'b0;
                slatch_d = 1'b1;
                if (phase_end) begin
                    div_d    = '0;
                    slatch_d = 1'b0;
                    busy_d   = 1'b0;
                    done_d   = 1'b1;
                end else begin
                    div_d = div_q + DIV_ONE;
                end
            end

            default: begin
                div_d    = '0;
                bit_d    = '0;
                shift_d  = '0;
                busy_d   = 1'b0;
                sclk_d   = 1'b0;
                sdat_d   = 1'b0;
                slatch_d = 1'b0;
            end
        endcase
    end

endmodule
